// File: rtl/block_sync_ml.sv
// block_sync_ml: multi-lane 64b/66b block synchroniser with slip hunt, loss-of-lock, hi-BER and slip-timeout
module block_sync_ml #(
  parameter int NLANE     = 4,
  parameter int LOCK_GOOD = 64,
  parameter int LOS_WIN   = 8,
  parameter int LOS_BAD   = 3,
  parameter int BLACKOUT  = 15,
  parameter int SLIP_TO   = 512,
  parameter int HIBER_WIN = 1024,
  parameter int HIBER_THR = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NLANE*66-1:0] gb_blk,
  input  logic [NLANE-1:0]    gb_blk_ena,
  input  logic [NLANE-1:0]    csr_bs_en,
  output logic [NLANE*64-1:0] bs_blk,
  output logic [NLANE*2-1:0]  bs_sh,
  output logic [NLANE-1:0]    bs_ena,
  output logic [NLANE-1:0]    blk_slip,
  output logic [NLANE-1:0]    csr_stat_block_lock,
  output logic [NLANE-1:0]    csr_expt_loss_blocklock,
  output logic [NLANE-1:0]    csr_expt_slip_to,
  output logic [NLANE-1:0]    csr_stat_hi_ber,
  output logic                csr_stat_all_lock
);
  localparam int GW = $clog2(LOCK_GOOD + 1);
  localparam int SW = $clog2(SLIP_TO + 1);
  localparam int BW = $clog2(BLACKOUT + 1);
  localparam int WW = $clog2(LOS_WIN + 1);
  localparam int LW = $clog2(LOS_BAD + 1);
  localparam int TW = $clog2(HIBER_WIN + 1);
  localparam int HW = $clog2(HIBER_THR + 1);
  typedef enum logic [1:0] {S_DISABLED, S_HUNT, S_BLACKOUT, S_LOCKED} state_t;
  for (genvar i = 0; i < NLANE; i++) begin : g_lane
    state_t st, st_n;
    logic [GW-1:0] good_cnt;
    logic [SW-1:0] slip_cnt;
    logic [BW-1:0] bo_cnt;
    logic [WW-1:0] win_cnt;
    logic [LW-1:0] bad_cnt, bad_nx;
    logic [TW-1:0] ber_tmr;
    logic [HW-1:0] ber_cnt, ber_nx;
    logic [1:0] sh, shr;
    logic [63:0] blk;
    logic off, v, good, bad, lock_evt, slip_evt, lose, bo_end;
    logic win_step, win_end, ber_step, ber_end, ber_hit;
    logic lock, loss, sto, hb, slip, ena;
    assign sh       = gb_blk[i*66 +: 2];
    assign off      = !csr_bs_en[i];
    assign v        = gb_blk_ena[i];
    assign bad      = v && (sh[0] == sh[1]);
    assign good     = v && (sh[0] != sh[1]);
    assign lock_evt = st == S_HUNT && good && good_cnt == GW'(LOCK_GOOD - 1);
    assign slip_evt = st == S_HUNT && bad;
    assign bo_end   = bo_cnt == BW'(BLACKOUT - 1);
    // an idle loss window (win_cnt == 0) is opened only by a bad header
    assign bad_nx   = bad_cnt + LW'(bad);
    assign lose     = st == S_LOCKED && bad && bad_nx >= LW'(LOS_BAD);
    assign win_step = st == S_LOCKED && v && (win_cnt != '0 || bad);
    assign win_end  = win_step && win_cnt == WW'(LOS_WIN - 1);
    assign ber_step = st == S_LOCKED && v;
    assign ber_end  = ber_tmr == TW'(HIBER_WIN - 1);
    assign ber_nx   = ber_cnt == HW'(HIBER_THR) ? ber_cnt : ber_cnt + HW'(bad);
    assign ber_hit  = ber_nx >= HW'(HIBER_THR);
    always_comb begin
      st_n = off ? S_DISABLED :
             st == S_DISABLED ? S_HUNT :
             lock_evt ? S_LOCKED :
             slip_evt ? S_BLACKOUT :
             (st == S_BLACKOUT && bo_end) || lose ? S_HUNT : st;
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st       <= S_DISABLED;
        good_cnt <= '0;
        slip_cnt <= '0;
        bo_cnt   <= '0;
        win_cnt  <= '0;
        bad_cnt  <= '0;
        ber_tmr  <= '0;
        ber_cnt  <= '0;
        lock     <= 1'b0;
        loss     <= 1'b0;
        sto      <= 1'b0;
        hb       <= 1'b0;
        slip     <= 1'b0;
        ena      <= 1'b0;
        blk      <= '0;
        shr      <= '0;
      end else begin
        st       <= st_n;
        good_cnt <= off || st != S_HUNT || bad || lock_evt ? '0 : good_cnt + GW'(good);
        slip_cnt <= off || lock_evt ? '0 : slip_cnt + SW'(slip_evt && slip_cnt != SW'(SLIP_TO));
        sto      <= !off && !lock_evt && (sto || slip_cnt == SW'(SLIP_TO));
        bo_cnt   <= !off && st == S_BLACKOUT && !bo_end ? bo_cnt + 1'b1 : '0;
        lock     <= st_n == S_LOCKED;
        loss     <= !off && (lose || (loss && !lock_evt));
        slip     <= !off && slip_evt;
        ena      <= !off && v && lock;
        win_cnt  <= st_n != S_LOCKED || win_end ? '0 : win_cnt + WW'(win_step);
        bad_cnt  <= st_n != S_LOCKED || win_end ? '0 : win_step ? bad_nx : bad_cnt;
        ber_tmr  <= st_n != S_LOCKED || (ber_step && ber_end) ? '0 : ber_tmr + TW'(ber_step);
        ber_cnt  <= st_n != S_LOCKED || (ber_step && ber_end) ? '0 : ber_step ? ber_nx : ber_cnt;
        hb       <= st_n != S_LOCKED ? 1'b0 : ber_step && ber_end ? ber_hit : hb || ber_hit;
        if (v) begin
          blk <= gb_blk[i*66+2 +: 64];
          shr <= sh;
        end
      end
    end
    assign bs_blk[i*64 +: 64]         = blk;
    assign bs_sh[i*2 +: 2]            = shr;
    assign bs_ena[i]                  = ena;
    assign blk_slip[i]                = slip;
    assign csr_stat_block_lock[i]     = lock;
    assign csr_expt_loss_blocklock[i] = loss;
    assign csr_expt_slip_to[i]        = sto;
    assign csr_stat_hi_ber[i]         = hb;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) csr_stat_all_lock <= 1'b0;
    else csr_stat_all_lock <= |csr_bs_en && &(csr_stat_block_lock | ~csr_bs_en);
  end
endmodule
